// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-stage access controller: datapath word type
// and the memory-stage FSM state encoding.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

package dp_types_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DONE,
        HFLUSH,
        HALTED
    } mem_state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of EX/MEM inputs, dcache port and pipeline control outputs seen by
// the memory-stage controller; slave is the controller, master its environment.
interface mem_access_ctrl_if #(parameter int CNT_W = 16);
    import cpu_types_pkg::*;

    logic             mem_valid;
    logic             mem_ren;
    logic             mem_wen;
    logic             mem_halt;
    word_t            mem_addr;
    word_t            mem_store;
    logic             dhit;
    word_t            dmemload;
    logic             flushed;
    logic             dmemREN;
    logic             dmemWEN;
    word_t            dmemaddr;
    word_t            dmemstore;
    logic             dcache_halt;
    logic             mem_stall;
    logic             mem_wb_flush;
    word_t            load_data;
    logic             halt_out;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output mem_valid, mem_ren, mem_wen, mem_halt, mem_addr, mem_store,
        output dhit, dmemload, flushed,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, dcache_halt,
        input  mem_stall, mem_wb_flush, load_data, halt_out, stall_cycles
    );

    modport slave (
        input  mem_valid, mem_ren, mem_wen, mem_halt, mem_addr, mem_store,
        input  dhit, dmemload, flushed,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, dcache_halt,
        output mem_stall, mem_wb_flush, load_data, halt_out, stall_cycles
    );
endinterface

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues dcache requests for the EX/MEM
// instruction, stalls the pipeline until dhit, and sequences the halt flush.
module mem_access_ctrl
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    mem_access_ctrl_if.slave  bus
);
    mem_state_t       state;
    mem_state_t       state_next;
    word_t            load_q;
    logic             is_halt;
    logic             is_access;
    logic             is_write;
    logic             is_read;
    logic             capture;
    logic             req;
    logic             stall;
    logic             count_inc;
    logic [CNT_W-1:0] count;

    // Halt outranks any load/store flags; write wins when both are set.
    assign is_halt   = bus.mem_valid & bus.mem_halt;
    assign is_access = bus.mem_valid & ~bus.mem_halt & (bus.mem_wen | bus.mem_ren);
    assign is_write  = is_access & bus.mem_wen;
    assign is_read   = is_access & bus.mem_ren & ~bus.mem_wen;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (is_halt) begin
                    state_next = HFLUSH;
                end else if (is_access) begin
                    state_next = bus.dhit ? DONE : WAIT;
                end
            end
            WAIT:    if (bus.dhit) state_next = DONE;
            DONE:    state_next = IDLE;
            HFLUSH:  if (bus.flushed) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    // Only loads carry data back; a completing store leaves a zero value.
    assign capture = bus.dhit & (((state == IDLE) & is_access) | (state == WAIT));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            load_q <= '0;
        end else if (capture) begin
            load_q <= is_read ? bus.dmemload : '0;
        end
    end

    always_comb begin
        req              = 1'b0;
        stall            = 1'b0;
        count_inc        = 1'b0;
        bus.dmemREN      = 1'b0;
        bus.dmemWEN      = 1'b0;
        bus.dmemaddr     = '0;
        bus.dmemstore    = '0;
        bus.dcache_halt  = 1'b0;
        bus.mem_stall    = 1'b0;
        bus.mem_wb_flush = 1'b0;
        bus.load_data    = '0;
        bus.halt_out     = 1'b0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    req             = is_access;
                    stall           = is_access | is_halt;
                    bus.dcache_halt = is_halt;
                end
                WAIT: begin
                    req   = is_access;
                    stall = 1'b1;
                end
                DONE:   bus.load_data = load_q;
                HFLUSH: begin
                    stall           = 1'b1;
                    bus.dcache_halt = 1'b1;
                end
                HALTED: begin
                    stall           = 1'b1;
                    bus.dcache_halt = 1'b1;
                    bus.halt_out    = 1'b1;
                end
                default: stall = 1'b0;
            endcase
            bus.dmemREN      = req & is_read;
            bus.dmemWEN      = req & is_write;
            bus.dmemaddr     = req ? bus.mem_addr : '0;
            bus.dmemstore    = req ? bus.mem_store : '0;
            bus.mem_stall    = stall;
            bus.mem_wb_flush = stall;
            count_inc        = stall & (state != HALTED);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (count_inc),
        .count (count)
    );

    assign bus.stall_cycles = count;
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller that consumes the EX/MEM pipeline register's output and produces that register's enable and flush controls. It issues data-cache read/write requests for the instruction held in EX/MEM and waits for `dhit`. It stalls the front of the pipeline until the access completes, and sequences the halt/flush handshake with the data cache. It sits between the EX/MEM register, the MEM/WB register and the dcache port of the datapath.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating stall-cycle counter.

Ports (one clock; reset is asynchronous and active-high):
- `CLK`  in  1  system clock, all state updates on rising edge
- `RST`  in  1  asynchronous, active-high reset
- `mem_valid`  in  1  EX/MEM output holds a valid instruction
- `mem_ren`  in  1  instruction is a load
- `mem_wen`  in  1  instruction is a store
- `mem_halt`  in  1  instruction is HALT
- `mem_addr`  in  32  effective address (word_t)
- `mem_store`  in  32  store data (word_t)
- `dhit`  in  1  dcache completes the current request this cycle
- `dmemload`  in  32  dcache read data, valid when `dhit`
- `flushed`  in  1  dcache write-back flush finished
- `dmemREN`  out  1  dcache read request
- `dmemWEN`  out  1  dcache write request
- `dmemaddr`  out  32  request address
- `dmemstore`  out  32  store data to dcache
- `dcache_halt`  out  1  request dcache flush
- `mem_stall`  out  1  drives `ex_mem_en` and all upstream enables low when 1
- `mem_wb_flush`  out  1  loads a bubble into MEM/WB
- `load_data`  out  32  completed load value to MEM/WB
- `halt_out`  out  1  CPU halted
- `stall_cycles`  out  CNT_W  saturating count of memory stall cycles

## Operation
- The access type is `mem_valid & ~mem_halt & (mem_wen | mem_ren)`. When both `mem_ren` and `mem_wen` are set, the access is a write and `dmemREN` stays 0.
- `dmemaddr` = `mem_addr` and `dmemstore` = `mem_store` while a request is driven. Otherwise both are 0.
- FSM states: IDLE, WAIT, DONE, HFLUSH, HALTED.
- **IDLE**:
  - On an access: drive the request and `mem_stall`=1. If `dhit` is 1 this cycle, capture `dmemload` into `load_q` and go to DONE. Otherwise go to WAIT.
  - If `mem_valid & mem_halt`: `mem_stall`=1, `dcache_halt`=1, go to HFLUSH. Halt has priority over `mem_ren`/`mem_wen`.
  - Otherwise: no request, `mem_stall`=0.
- **WAIT**: hold the request and `mem_stall`=1. On `dhit`, capture `load_q` and go to DONE.
- **DONE**: no request, `mem_stall`=0, `load_data`=`load_q`. EX/MEM and MEM/WB advance at this edge. Next state is IDLE.
- **HFLUSH**: `dcache_halt`=1, `mem_stall`=1. On `flushed`, go to HALTED.
- **HALTED**: `halt_out`=1, `mem_stall`=1, `dcache_halt`=1. Leaves only on reset.
- `mem_wb_flush` = `mem_stall`. A stalled memory instruction never commits twice.
- `load_data` = `load_q` in DONE and 0 in every other state.
- `stall_cycles` increments every cycle `mem_stall`=1 in IDLE, WAIT or HFLUSH. It does not count in HALTED and saturates at all-ones with no wrap.
- `dhit` outside IDLE/WAIT and `flushed` outside HFLUSH are ignored.

## Timing
- Reset values: state IDLE, `load_q`=0, `stall_cycles`=0. While `RST`=1, every output is forced to 0, including combinational request outputs.
- Reset mid-access (WAIT or HFLUSH) drops the requests immediately and asynchronously. The access is abandoned.
- Minimum access is 2 cycles: request cycle with `dhit`, then DONE.
- An access whose `dhit` arrives N cycles after the first request cycle takes N+2 cycles. `mem_stall` is high for N+1 of them.
- `mem_stall` depends combinationally on state and the EX/MEM inputs only, never on `dhit`. `dhit` only affects the next state.
- A new instruction in EX/MEM is first evaluated in the cycle after DONE.

## Structure
- `mem_state_t` (IDLE, WAIT, DONE, HFLUSH, HALTED) goes in `dp_types_pkg`. `word_t` comes from `cpu_types_pkg`.
- Sub-module `sat_counter` (parameter `W`; inputs `inc`; output `count`) implements `stall_cycles`.
- The FSM uses a registered state with a combinational next-state/output block. `load_q` is a separate register.

## Test plan
- **Load hit:** load at 0x0000_0040 with `dhit`=1 in the first cycle and `dmemload`=0xDEADBEEF. Required: `dmemREN`=1 for 1 cycle, `mem_stall`=1 for 1 cycle, then DONE with `load_data`=0xDEADBEEF. `stall_cycles`=1.
- **Store miss:** `dhit` arrives 3 cycles late, `mem_store`=0x1234_5678. Required: `dmemWEN`=1 for 4 cycles with stable addr/data, `mem_stall`=1 for 4 cycles, DONE in cycle 5, `load_data`=0.
- **Both ren and wen:** `mem_ren`=`mem_wen`=1. Required: only `dmemWEN` asserted.
- **Halt:** HALT with `mem_ren`=1. Required: no dcache request and `dcache_halt`=1. `flushed` after 5 cycles gives HALTED. `halt_out`=1 and `mem_stall` stays 1 thereafter.
- **Reset mid-miss:** assert `RST` in WAIT. Required: `dmemREN`=0 in the same cycle, state IDLE, `stall_cycles`=0. After release, an idle `mem_valid`=0 input gives no request.
- **Saturation:** with `CNT_W`=4, a 20-cycle miss leaves `stall_cycles`=15, with no wrap.
